tristate_bus_arbiter: RTL and testbench
=======================================

// Module: tristate_bus_arbiter
// PURPOSE
//   Round-robin owner controller for a shared tri-state bus driven by N_REQ agents.
//   Each agent drives the bus only while its oe bit is high, and floats it (z) otherwise.
//   The block guarantees that at most one oe bit is high in any cycle.
//   It inserts TURN_CYCLES all-floating cycles between owners, so the resolved bus never sees X from contention.
//   It sits beside the bus wiring: agents raise req, wait for grant, drive, then drop req.
// PARAMETERS
//   N_REQ        4   number of requesters/drivers; legal range >=2
//   TURN_CYCLES  1   all-oe-low turnaround cycles after every release; legal range >=0
//   MAX_HOLD     16  max consecutive granted cycles before forced release; 0 = unlimited
// PORTS
//   clk       in   1            rising-edge clock
//   rst       in   1            asynchronous reset, active-high
//   req       in   N_REQ        level request per agent; held high while it wants or owns the bus
//   grant     out  N_REQ        registered one-hot grant; all-zero when no owner
//   oe        out  N_REQ        tri-state output enables; identical to grant, separate port for pad wiring
//   owner     out  OWN_W        index of current/last grantee; OWN_W = $clog2(N_REQ)
//   bus_idle  out  1            1 when grant == 0 (combinational from registered grant)
//   preempt   out  1            one-cycle pulse on the cycle after a MAX_HOLD forced release
// BEHAVIOUR
//   Reset (async, takes effect immediately, not at the next edge):
//   - Outputs: grant=0, oe=0, owner=0, bus_idle=1, preempt=0.
//   - Internal: state=IDLE, hold count=0, RR pointer=N_REQ-1, so agent 0 has first priority.
//   States: IDLE, GRANT, TURN.
//   IDLE:
//   - At an edge with |req, choose the first set req[i] scanning from ptr+1 upward, wrapping.
//   - Then set grant[i]=1, owner=i, ptr=i, hold=1, and go to GRANT.
//   - Latency is one edge: req sampled at edge k gives grant high after edge k.
//   GRANT:
//   - Voluntary release: if req[owner]==0 at an edge, clear grant and go to TURN.
//   - Forced release: if MAX_HOLD!=0 && hold==MAX_HOLD && req[owner]==1 at an edge, clear grant, pulse preempt for the next cycle, and go to TURN.
//   - Otherwise hold++.
//   - The grant is therefore high for at most MAX_HOLD cycles.
//   - The hold counter saturates and never wraps; its width is $clog2(MAX_HOLD+1), minimum 1.
//   - Requests from other agents during GRANT are ignored; there is no priority preemption.
//   TURN:
//   - Keep grant=0 for exactly TURN_CYCLES cycles.
//   - On the edge ending the last turn cycle, arbitrate as in IDLE: go to GRANT if |req, else IDLE.
//   - If TURN_CYCLES==0, the release edge arbitrates directly.
//   - In that case the new one-hot grant replaces the old one in a single edge, with no zero cycle; the release is still registered.
//   - A preempted agent that keeps req high is rescanned last (ptr = its index).
//   Invariants:
//   - $onehot0(grant) at all times.
//   - grant is never asserted to an agent whose req was low at the granting edge.
//   - owner holds its value after release.
//   Simultaneous events:
//   - Owner drops req on the same edge MAX_HOLD is reached: voluntary release, preempt=0.
//   - Several new reqs rise together: the RR scan decides.
//   Req handling: req bits are sampled only at clk edges; bits that are z/x in simulation are treated as not requesting (the comparison is ==1'b1).
// TESTING
//   1. rst=1 with req=4'b1111 -> grant=0, oe=0, bus_idle=1. Deassert rst -> after 1st edge grant=4'b0001, owner=0.
//   2. MAX_HOLD=4, TURN=1, req=4'b1111 held -> 0001 x4 cycles, 0000 x1, 0010 x4, 0000, 0100, 0000, 1000, 0000, 0001. preempt pulses in each 0000 cycle.
//   3. req=4'b0100 high 3 cycles then low -> grant=0100 for 3 cycles (1-edge lag), 1 zero cycle, then IDLE with bus_idle=1 and owner=2.
//   4. Bench models bus = oe[i] ? 8'hA0+i : 8'hzz for four drivers, 2000 random req cycles -> bus never X, bus==8'hzz whenever bus_idle, $onehot0(oe) every cycle.
//   5. Assert rst #1 after an edge while grant=4'b0010 -> grant=0 and oe=0 at #2 before the next edge. After rst release with req=1111 -> grant=4'b0001.
//   6. TURN_CYCLES=0, MAX_HOLD=0, req0 drops while req1=1 -> grant goes 0001 to 0010 in one edge with no zero cycle, and preempt stays 0.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner controller for a shared tri-state bus: one-hot grant/oe,
// bounded hold time, and all-floating turnaround cycles between owners.
module tristate_bus_arbiter #(
   parameter  int N_REQ       = 4,
   parameter  int TURN_CYCLES = 1,
   parameter  int MAX_HOLD    = 16,
   localparam int OWN_W       = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [N_REQ-1:0] oe,
   output logic [OWN_W-1:0] owner,
   output logic             bus_idle,
   output logic             preempt
);

   localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam int TURN_W = (TURN_CYCLES < 2) ? 1 : $clog2(TURN_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

   state_t            r_state, w_state_nxt;
   logic [N_REQ-1:0]  r_grant, w_grant_nxt;
   logic [OWN_W-1:0]  r_owner, w_owner_nxt;
   logic [OWN_W-1:0]  r_ptr, w_ptr_nxt;
   logic [HOLD_W-1:0] r_hold, w_hold_nxt;
   logic [TURN_W-1:0] r_turn, w_turn_nxt;
   logic              r_preempt, w_preempt_nxt;

   logic [N_REQ-1:0]  w_req;
   logic [OWN_W-1:0]  w_scan;
   logic [OWN_W-1:0]  w_pick_idx;
   logic              w_pick_vld;
   logic              w_arb;
   logic              w_rel;

   // Undriven or unknown request bits never count as requesting.
   always_comb begin
      w_req = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (req[i] == 1'b1) w_req[i] = 1'b1;
      end
   end

   always_comb begin
      w_pick_vld = 1'b0;
      w_pick_idx = '0;
      w_scan     = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         w_scan = OWN_W'((32'(r_ptr) + k) % N_REQ);
         if (!w_pick_vld && w_req[w_scan]) begin
            w_pick_vld = 1'b1;
            w_pick_idx = w_scan;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_owner_nxt   = r_owner;
      w_ptr_nxt     = r_ptr;
      w_hold_nxt    = r_hold;
      w_turn_nxt    = r_turn;
      w_preempt_nxt = 1'b0;
      w_arb         = 1'b0;
      w_rel         = 1'b0;

      unique case (r_state)
         S_IDLE: w_arb = 1'b1;
         S_GRANT: begin
            if (!w_req[r_owner]) begin
               w_rel = 1'b1;
            end else if (MAX_HOLD != 0 && r_hold == HOLD_W'(MAX_HOLD)) begin
               w_rel         = 1'b1;
               w_preempt_nxt = 1'b1;
            end else if (r_hold != '1) begin
               w_hold_nxt = r_hold + 1'b1;
            end
         end
         S_TURN: begin
            if (r_turn == TURN_W'(TURN_CYCLES)) w_arb = 1'b1;
            else                                w_turn_nxt = r_turn + 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // With no turnaround the release edge also arbitrates, swapping owners in one edge.
      if (w_rel) begin
         w_grant_nxt = '0;
         if (TURN_CYCLES == 0) begin
            w_arb = 1'b1;
         end else begin
            w_state_nxt = S_TURN;
            w_turn_nxt  = TURN_W'(1);
         end
      end

      if (w_arb) begin
         w_grant_nxt = '0;
         if (w_pick_vld) begin
            w_grant_nxt[w_pick_idx] = 1'b1;
            w_owner_nxt = w_pick_idx;
            w_ptr_nxt   = w_pick_idx;
            w_hold_nxt  = HOLD_W'(1);
            w_state_nxt = S_GRANT;
         end else begin
            w_state_nxt = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_grant   <= '0;
         r_owner   <= '0;
         r_ptr     <= OWN_W'(N_REQ - 1);
         r_hold    <= '0;
         r_turn    <= '0;
         r_preempt <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_owner   <= w_owner_nxt;
         r_ptr     <= w_ptr_nxt;
         r_hold    <= w_hold_nxt;
         r_turn    <= w_turn_nxt;
         r_preempt <= w_preempt_nxt;
      end
   end

   assign grant    = r_grant;
   assign oe       = r_grant;
   assign owner    = r_owner;
   assign bus_idle = (r_grant == '0);
   assign preempt  = r_preempt;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench for tristate_bus_arbiter: directed tables, a cycle model
// for random traffic, and a resolved-bus check for four modelled drivers.
module tb_tristate_bus_arbiter;

   localparam int MH_A = 4;
   localparam int TC_A = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req_a = '0, req_b = '0;
   logic [3:0] grant_a, oe_a, grant_b, oe_b;
   logic [1:0] owner_a, owner_b;
   logic       idle_a, idle_b, pre_a, pre_b;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] o;
      logic       p;
   } exp_t;

   exp_t sb[$];

   // reference model state for instance A
   int         m_st, m_hold, m_turn;
   logic [3:0] m_grant;
   logic [1:0] m_owner, m_ptr;
   logic       m_pre;

   always #5 clk = ~clk;

   tristate_bus_arbiter #(.N_REQ(4), .TURN_CYCLES(TC_A), .MAX_HOLD(MH_A)) u_a (
      .clk(clk), .rst(rst), .req(req_a), .grant(grant_a), .oe(oe_a),
      .owner(owner_a), .bus_idle(idle_a), .preempt(pre_a)
   );

   tristate_bus_arbiter #(.N_REQ(4), .TURN_CYCLES(0), .MAX_HOLD(0)) u_b (
      .clk(clk), .rst(rst), .req(req_b), .grant(grant_b), .oe(oe_b),
      .owner(owner_b), .bus_idle(idle_b), .preempt(pre_b)
   );

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      sb.delete();
      m_st = 0; m_grant = '0; m_owner = '0; m_ptr = 2'd3;
      m_hold = 0; m_turn = 0; m_pre = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic m_arb(input logic [3:0] r);
      int c;
      m_grant = '0;
      m_st    = 0;
      for (int k = 1; k <= 4; k++) begin
         c = (int'(m_ptr) + k) % 4;
         if (r[c]) begin
            m_grant = 4'(1 << c);
            m_owner = 2'(c);
            m_ptr   = 2'(c);
            m_hold  = 1;
            m_st    = 1;
            break;
         end
      end
   endtask

   task automatic m_step(input logic [3:0] r);
      exp_t e;
      m_pre = 1'b0;
      case (m_st)
         0: m_arb(r);
         1: begin
            if (!r[m_owner]) begin
               m_grant = '0; m_st = 2; m_turn = 1;
            end else if (m_hold == MH_A) begin
               m_grant = '0; m_st = 2; m_turn = 1; m_pre = 1'b1;
            end else begin
               m_hold++;
            end
         end
         default: begin
            if (m_turn >= TC_A) m_arb(r);
            else                m_turn++;
         end
      endcase
      e.g = m_grant; e.o = m_owner; e.p = m_pre;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      req_a = 4'b1111;
      req_b = 4'b0000;
      #1 rst = 1'b1;
      #2;
      n_tests++;
      if ({grant_a, oe_a, idle_a, owner_a, pre_a} !== {4'b0, 4'b0, 1'b1, 2'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_async: got grant=%b oe=%b idle=%b owner=%0d pre=%b, want 0000 0000 1 0 0",
                  grant_a, oe_a, idle_a, owner_a, pre_a);
      end
      @(posedge clk); #1;
      n_tests++;
      if (grant_a !== 4'b0000 || idle_a !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_held: got grant=%b idle=%b, want 0000 1", grant_a, idle_a);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (grant_a !== 4'b0001 || owner_a !== 2'd0 || idle_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_first_grant: got grant=%b owner=%0d idle=%b, want 0001 0 0",
                  grant_a, owner_a, idle_a);
      end
   endtask

   task automatic test_rr_preempt();
      exp_t e, got;
      req_a = 4'b1111;
      do_reset();
      for (int i = 0; i < 21; i++) begin
         if (i == 20) begin
            e.g = 4'b0001; e.o = 2'd0; e.p = 1'b0;
         end else begin
            e.g = ((i % 5) < 4) ? 4'(1 << (i / 5)) : 4'b0000;
            e.o = 2'(i / 5);
            e.p = ((i % 5) == 4);
         end
         sb.push_back(e);
         @(posedge clk); #1;
         got = sb.pop_front();
         n_tests++;
         if ({grant_a, oe_a, owner_a, pre_a, idle_a} !== {got.g, got.g, got.o, got.p, got.g == 4'b0}) begin
            n_fail++;
            $display("FAIL rr_preempt[%0d]: got grant=%b oe=%b owner=%0d pre=%b idle=%b, want grant=%b owner=%0d pre=%b",
                     i, grant_a, oe_a, owner_a, pre_a, idle_a, got.g, got.o, got.p);
         end
      end
   endtask

   task automatic test_release();
      exp_t e, got;
      req_a = 4'b0000;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         req_a = (i < 3) ? 4'b0100 : 4'b0000;
         e.g = (i < 3) ? 4'b0100 : 4'b0000; e.o = 2'd2; e.p = 1'b0;
         sb.push_back(e);
         @(posedge clk); #1;
         got = sb.pop_front();
         n_tests++;
         if ({grant_a, oe_a, owner_a, pre_a, idle_a} !== {got.g, got.g, got.o, got.p, got.g == 4'b0}) begin
            n_fail++;
            $display("FAIL release[%0d]: got grant=%b owner=%0d pre=%b idle=%b, want grant=%b owner=%0d pre=%b",
                     i, grant_a, owner_a, pre_a, idle_a, got.g, got.o, got.p);
         end
      end
   endtask

   task automatic test_random();
      exp_t got;
      int   n_drv;
      logic [7:0] bus_val;
      req_a = 4'b0000;
      do_reset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 7) == 0) req_a[b] = ~req_a[b];
         end
         m_step(req_a);
         @(posedge clk); #1;
         got = sb.pop_front();
         n_tests++;
         if ({grant_a, owner_a, pre_a} !== {got.g, got.o, got.p}) begin
            n_fail++;
            $display("FAIL random_model[%0d]: got grant=%b owner=%0d pre=%b, want grant=%b owner=%0d pre=%b",
                     cyc, grant_a, owner_a, pre_a, got.g, got.o, got.p);
         end
         n_drv   = 0;
         bus_val = 8'h00;
         for (int d = 0; d < 4; d++) begin
            if (oe_a[d]) begin
               n_drv++;
               bus_val = 8'hA0 + 8'(d);
            end
         end
         n_tests++;
         if (n_drv > 1) begin
            n_fail++;
            $display("FAIL bus_contention[%0d]: %0d drivers (last %h), want at most 1", cyc, n_drv, bus_val);
         end
         n_tests++;
         if (idle_a && n_drv != 0) begin
            n_fail++;
            $display("FAIL bus_idle_float[%0d]: %0d drivers while idle, want 0", cyc, n_drv);
         end
         n_tests++;
         if (!$onehot0(oe_a) || oe_a !== grant_a) begin
            n_fail++;
            $display("FAIL oe_onehot[%0d]: got oe=%b grant=%b, want one-hot-or-zero and equal", cyc, oe_a, grant_a);
         end
      end
   endtask

   task automatic test_async_reset();
      req_a = 4'b1111;
      do_reset();
      repeat (6) begin
         @(posedge clk); #1;
      end
      n_tests++;
      if (grant_a !== 4'b0010) begin
         n_fail++;
         $display("FAIL async_pre: got grant=%b, want 0010", grant_a);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if ({grant_a, oe_a, idle_a, owner_a, pre_a} !== {4'b0, 4'b0, 1'b1, 2'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL async_mid: got grant=%b oe=%b idle=%b owner=%0d pre=%b, want 0000 0000 1 0 0",
                  grant_a, oe_a, idle_a, owner_a, pre_a);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (grant_a !== 4'b0001 || owner_a !== 2'd0) begin
         n_fail++;
         $display("FAIL async_after: got grant=%b owner=%0d, want 0001 0", grant_a, owner_a);
      end
   endtask

   task automatic test_zero_turn();
      exp_t e, got;
      req_a = 4'b0000;
      req_b = 4'b0011;
      do_reset();
      for (int i = 0; i < 26; i++) begin
         req_b = (i < 20) ? 4'b0011 : ((i < 24) ? 4'b0010 : 4'b0000);
         e.g = (i < 20) ? 4'b0001 : ((i < 24) ? 4'b0010 : 4'b0000);
         e.o = (i < 20) ? 2'd0 : 2'd1;
         e.p = 1'b0;
         sb.push_back(e);
         @(posedge clk); #1;
         got = sb.pop_front();
         n_tests++;
         if ({grant_b, oe_b, owner_b, pre_b, idle_b} !== {got.g, got.g, got.o, got.p, got.g == 4'b0}) begin
            n_fail++;
            $display("FAIL zero_turn[%0d]: got grant=%b owner=%0d pre=%b idle=%b, want grant=%b owner=%0d pre=%b",
                     i, grant_b, owner_b, pre_b, idle_b, got.g, got.o, got.p);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rr_preempt();
      test_release();
      test_random();
      test_async_reset();
      test_zero_turn();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "timeout");
   end

endmodule
